// File: rtl/controller_rom_loader.sv
// Packs a host byte stream into big-endian 32-bit words and writes them to the
// byte-enabled controller ROM, one strobe per word, partial last word by lane mask.
module controller_rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  rom_we,
  output logic [3:0]            rom_bytesel,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_d,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH+1:0] byte_count
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, DRAIN, FIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [1:0]            lane;
  logic [3:0]            mask;
  logic [31:0]           pack;
  logic                  word_last;
  logic [3:0]            sel_hold;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [31:0]           d_hold;
  logic                  xfer;
  logic                  ptr_at_top;

  assign xfer       = in_valid & in_ready;
  assign ptr_at_top = &word_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (xfer && (lane == 2'd3 || in_last)) state_next = WRITE;
      WRITE: begin
        if (word_last)       state_next = FIN;
        else if (ptr_at_top) state_next = DRAIN;
        else                 state_next = FILL;
      end
      DRAIN:   if (xfer && in_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ROM port shows the live word only during WRITE and otherwise replays the last write
  always_comb begin
    in_ready    = (state == FILL) || (state == DRAIN);
    busy        = (state != IDLE);
    done        = (state == FIN);
    rom_we      = (state == WRITE);
    rom_bytesel = (state == WRITE) ? mask     : sel_hold;
    rom_addr    = (state == WRITE) ? word_ptr : addr_hold;
    rom_d       = (state == WRITE) ? pack     : d_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_ptr   <= '0;
      lane       <= '0;
      mask       <= '0;
      pack       <= '0;
      word_last  <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
      sel_hold   <= '0;
      addr_hold  <= '0;
      d_hold     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            word_ptr   <= base_addr;
            byte_count <= '0;
            overflow   <= 1'b0;
            lane       <= '0;
            mask       <= '0;
            pack       <= '0;
            word_last  <= 1'b0;
          end
        end
        FILL: begin
          // lane 0 lands in the most significant byte (big-endian packing)
          if (xfer) begin
            pack[{~lane, 3'b000} +: 8] <= in_data;
            mask[lane]                 <= 1'b1;
            lane                       <= lane + 2'd1;
            byte_count                 <= byte_count + 1'b1;
            word_last                  <= in_last;
          end
        end
        WRITE: begin
          sel_hold  <= mask;
          addr_hold <= word_ptr;
          d_hold    <= pack;
          mask      <= '0;
          lane      <= '0;
          pack      <= '0;
          word_last <= 1'b0;
          if (!word_last) begin
            if (ptr_at_top) overflow <= 1'b1;
            else            word_ptr <= word_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_rom_loader.sv
// Scoreboard bench for controller_rom_loader: a word-level model predicts each
// ROM write and the end-of-upload status; a monitor pops and compares them.
module tb_controller_rom_loader;

  localparam int AW   = 5;
  localparam int MAXA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          rom_we;
  logic [3:0]    rom_bytesel;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_d;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW+1:0] byte_count;

  always #5 clk = ~clk;

  controller_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .rom_we(rom_we), .rom_bytesel(rom_bytesel), .rom_addr(rom_addr), .rom_d(rom_d),
    .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
  );

  typedef struct { logic [AW-1:0] addr; logic [3:0] sel; logic [31:0] d; } wr_t;
  typedef struct { logic [AW+1:0] bc; logic ov; } fin_t;

  wr_t        exp_wr[$];
  fin_t       exp_fin[$];
  logic [7:0] up_bytes[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  logic       prev_xfer = 1'b0;
  wr_t        mon_w;
  fin_t       mon_f;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe and done pulse is matched against the model queues
  always @(negedge clk) begin
    if (reset) begin
      prev_xfer = 1'b0;
    end else begin
      if (rom_we) begin
        check_output("write_latency", 64'(prev_xfer), 64'd1);
        check_output("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          check_output("rom_addr", 64'(rom_addr), 64'(mon_w.addr));
          check_output("rom_bytesel", 64'(rom_bytesel), 64'(mon_w.sel));
          check_output("rom_d", 64'(rom_d), 64'(mon_w.d));
        end
      end
      if (done) begin
        done_cnt++;
        check_output("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        check_output("done_expected", 64'(exp_fin.size() != 0), 64'd1);
        if (exp_fin.size() != 0) begin
          mon_f = exp_fin.pop_front();
          check_output("byte_count", 64'(byte_count), 64'(mon_f.bc));
          check_output("overflow", 64'(overflow), 64'(mon_f.ov));
        end
      end
      prev_xfer = in_valid & in_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap,
                           input logic restart, input logic [AW-1:0] rbase);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    if (restart) begin
      start     = 1'b1;
      base_addr = rbase;
    end
    while (!acc && t < 16) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      start = 1'b0;
      t++;
    end
    check_output("byte_accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Model: chop the byte list into 4-byte words, one write per word until the top address
  task automatic run_upload(input logic [AW-1:0] base, input int gap_mode, input bit restart);
    int   n, nwords, bc, d0, t, a, g;
    bit   ov;
    wr_t  w;
    fin_t f;
    n = up_bytes.size();
    nwords = (n + 3) / 4;
    bc = 0;
    ov = 0;
    for (int wi = 0; wi < nwords; wi++) begin
      a = int'(base) + wi;
      if (a > MAXA) begin
        ov = 1;
        break;
      end
      w.addr = a[AW-1:0];
      w.sel  = '0;
      w.d    = '0;
      for (int k = 0; k < 4 && 4 * wi + k < n; k++) begin
        w.sel[k]           = 1'b1;
        w.d[31 - 8*k -: 8] = up_bytes[4 * wi + k];
        bc++;
      end
      exp_wr.push_back(w);
    end
    f.bc = bc[AW+1:0];
    f.ov = ov;
    exp_fin.push_back(f);

    d0 = done_cnt;
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(up_bytes[i], i == n - 1, g, restart && i == 2, base ^ AW'(9));
    end
    t = 0;
    while (done_cnt == d0 && t < 30) begin
      tick();
      t++;
    end
    check_output("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (3) tick();
    check_output("done_once", 64'(done_cnt - d0), 64'd1);
    check_output("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    #3;
    check_output("reset_outputs",
      64'({in_ready, rom_we, rom_bytesel, rom_addr, rom_d, busy, done, overflow, byte_count}), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] full words");
    up_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_upload(AW'(5'h10), 0, 0);

    $display("[TB] partial final word");
    up_bytes = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_upload(AW'(0), 0, 0);
    check_output("hold_rom_d", 64'(rom_d), 64'h00000000EEFF0000);
    check_output("hold_bytesel", 64'(rom_bytesel), 64'h3);

    $display("[TB] handshake gaps");
    up_bytes = {8'h11, 8'h22, 8'h33, 8'h44};
    run_upload(AW'(7), 1, 0);

    $display("[TB] overflow");
    up_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_upload(AW'(MAXA), 0, 0);
    check_output("overflow_sticky", 64'(overflow), 64'd1);
    check_output("byte_count_hold", 64'(byte_count), 64'd4);

    $display("[TB] reset mid-upload");
    start = 1'b1;
    base_addr = AW'(3);
    tick();
    start = 1'b0;
    send_byte(8'h5A, 1'b0, 0, 1'b0, '0);
    send_byte(8'hA5, 1'b0, 0, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    check_output("reset_mid_outputs",
      64'({in_ready, rom_we, rom_bytesel, rom_addr, rom_d, busy, done, overflow, byte_count}), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    up_bytes = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_upload(AW'(3), 0, 0);

    $display("[TB] start while busy");
    up_bytes = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    run_upload(AW'(2), 0, 1);

    $display("[TB] randomized uploads");
    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(1, 20));
      up_bytes.delete();
      for (int i = 0; i < n; i++) up_bytes.push_back(8'($urandom));
      run_upload(AW'($urandom_range(0, MAXA)), int'($urandom_range(0, 2)),
                 (n > 3) && ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controller_rom_loader.md
Name: controller_rom_loader

Overview:
- Write-side initiator for the byte-enabled 32-bit controller ROM/RAM.
- Accepts a host upload byte stream (valid/ready, with a last flag) and packs the bytes into 32-bit big-endian words.
- Issues one write per word on the ROM's we/bytesel/addr/d port; a partial final word writes only its valid lanes.
- Sits between the upload/data_io path and the controller ROM write port.

Parameters:
- ADDR_WIDTH, 15, word-address width of the target ROM (depth 2**ADDR_WIDTH words).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin upload at base_addr; ignored unless in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, sampled on accepted start.
- in_valid  in  1  byte available.
- in_data  in  8  byte value.
- in_last  in  1  qualifies the final byte of the upload.
- in_ready  out  1  loader accepts a byte this cycle (transfer = in_valid & in_ready).
- rom_we  out  1  write strobe to the ROM, one cycle per word.
- rom_bytesel  out  4  lane enables; bit k selects byte k of the word.
- rom_addr  out  ADDR_WIDTH  word address.
- rom_d  out  32  write data; byte k on bits [31-8k:24-8k].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the upload completes.
- overflow  out  1  sticky; set when data exceeds the top address; cleared by an accepted start.
- byte_count  out  ADDR_WIDTH+2  bytes written to the ROM in the current/last upload.

Behaviour:
- Reset (async, active-high) drives the block to IDLE with all of the following outputs low or zero: in_ready, rom_we, rom_bytesel, rom_addr, rom_d, busy, done, overflow, byte_count. Packing register and lane mask are cleared. Reset mid-upload aborts with no further write and no done pulse.
- States: IDLE, FILL, WRITE, DRAIN, FIN.
- IDLE: in_ready=0. On start: word pointer <= base_addr, byte_count <= 0, overflow <= 0, lane index <= 0, mask <= 0; next state FILL.
- FILL: in_ready=1. On each transfer:
  - byte goes to lane index i: packing reg bits [31-8i:24-8i], mask[i] <= 1.
  - i increments; byte_count increments.
  - If i==3 or in_last, next state is WRITE.
- WRITE: in_ready=0; rom_we=1 for exactly this cycle.
  - rom_bytesel = mask, rom_addr = word pointer, rom_d = packing reg, with unfilled lanes driven 0.
  - Latency: the 4th (or last) byte accepted in cycle N is written in cycle N+1. Sustained rate is 4 bytes per 5 cycles.
  - After the write: mask, i and packing reg clear.
  - If the word was last: go to FIN.
  - Else if word pointer == all ones: set overflow and go to DRAIN; the pointer does not wrap.
  - Else: increment word pointer and go to FILL.
- DRAIN: in_ready=1. Bytes are accepted and discarded; byte_count is frozen and rom_we stays 0. A transfer with in_last goes to FIN.
- FIN: done=1 for one cycle, then IDLE. overflow and byte_count hold until the next accepted start.
- Outside WRITE: rom_we=0; rom_bytesel, rom_addr and rom_d hold their last values.
- start asserted while busy is ignored.
- in_last on the 4th byte of a word produces a single write, not a second empty one.
- in_valid gaps are allowed anywhere; the state is held.
- in_last with the stream empty cannot occur; in_last always qualifies a byte.

Test Plan:
- Full words: base_addr=0x10, bytes 01..08, last on 08 -> two writes: addr 0x10 d=0x01020304 sel=1111, then addr 0x11 d=0x05060708 sel=1111. done pulses once; byte_count=8; overflow=0.
- Partial word: base 0, bytes AA BB CC DD EE FF, last on FF -> second write addr 1 d=0xEEFF0000 sel=0011.
- Handshake gaps: in_valid toggling every other cycle with bytes 11 22 33 44 (last) -> exactly one rom_we pulse, one cycle after 44 is accepted; d=0x11223344.
- Overflow: ADDR_WIDTH=2, base 3, 8 bytes 01..08 -> single write addr 3 d=0x01020304. in_ready stays high through the drain; overflow=1; byte_count=4; done after 08.
- Reset mid-upload: assert reset after 2 bytes -> all outputs 0 immediately with no write. A subsequent start with 4 bytes writes normally.
- start while busy: pulse start during FILL with a different base_addr -> ignored; writes continue at the original addresses.
